// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped L1 data cache.
package dcache_pkg;

    // Geometry of the default configuration: 16 lines of 256 bits (8 x 32-bit words).
    localparam int LINES_DEFAULT = 16;
    localparam int OFFSET_W      = 5;
    localparam int INDEX_W       = $clog2(LINES_DEFAULT);
    localparam int TAG_W         = 32 - OFFSET_W - INDEX_W;
    localparam int WORD_SEL_W    = 3;
    localparam int WORD_W        = 32;

    // Controller state: idle/hit service, victim write-back, line refill.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signals of the data cache. Signal suffixes are
// written from the controller's point of view (_i into the cache, _o out of it).
interface dcache_controller_if #(
    parameter int LINE_W = 256
);
    // CPU MEM-stage port
    logic              cpu_req_i;
    logic              cpu_write_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;

    // Off-chip line memory port
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // The cache controller itself.
    modport slave (
        input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    // The environment around it: pipeline plus memory.
    modport master (
        output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_sram.sv
// Line storage for the direct-mapped cache: valid/dirty flags, tags and data.
// Combinational read by index; synchronous write of a full line (refill) or a
// single word (store hit). Only the flags are cleared by reset.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int LINE_W = 256,
    parameter int IDX_W  = $clog2(LINES),
    parameter int TG_W   = 32 - OFFSET_W - IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // read port
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TG_W-1:0]       rd_tag_o,
    output logic [LINE_W-1:0]     rd_data_o,
    // write port
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic                  line_we_i,
    input  logic [TG_W-1:0]       line_tag_i,
    input  logic [LINE_W-1:0]     line_data_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_data_i
);

    logic [LINES-1:0]  valid_vec;
    logic [LINES-1:0]  dirty_vec;
    logic [TG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    logic [WORD_SEL_W+4:0] word_lsb;
    assign word_lsb = {word_sel_i, 5'b00000};

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_flags
            logic valid_bit_q;
            logic dirty_bit_q;

            // A refill installs a clean valid line; a store hit marks it dirty.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    valid_bit_q <= 1'b0;
                    dirty_bit_q <= 1'b0;
                end else if (line_we_i && (wr_idx_i == IDX_W'(gi))) begin
                    valid_bit_q <= 1'b1;
                    dirty_bit_q <= 1'b0;
                end else if (word_we_i && (wr_idx_i == IDX_W'(gi))) begin
                    dirty_bit_q <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_bit_q;
            assign dirty_vec[gi] = dirty_bit_q;
        end
    endgenerate

    // Tag and data arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_mem[wr_idx_i]  <= line_tag_i;
            data_mem[wr_idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_mem[wr_idx_i][word_lsb +: WORD_W] <= word_data_i;
        end
    end

    assign rd_valid_o = valid_vec[rd_idx_i];
    assign rd_dirty_o = dirty_vec[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete combinationally with no stall; a miss stalls the pipeline,
// writes back a dirty victim if needed, refills the line, then lets the held
// request complete as an ordinary hit.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    dcache_controller_if.slave bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TG_W  = 32 - OFFSET_W - IDX_W;

    // Address fields of the current CPU request.
    logic [TG_W-1:0]       req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_SEL_W-1:0] req_wsel;
    logic [1:0]            unused_byte_off;

    assign req_tag         = bus.cpu_addr_i[31 -: TG_W];
    assign req_idx         = bus.cpu_addr_i[OFFSET_W +: IDX_W];
    assign req_wsel        = bus.cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_byte_off = bus.cpu_addr_i[1:0];

    // Registered FSM state and memory-side outputs.
    dc_state_e         state_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [31:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;
    // Line being filled; kept so the fill completes even if the request drops.
    logic [TG_W-1:0]   fill_tag_q;
    logic [IDX_W-1:0]  fill_idx_q;

    // Storage read/write signals.
    logic              rd_valid;
    logic              rd_dirty;
    logic [TG_W-1:0]   rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              line_we;
    logic              word_we;
    logic [IDX_W-1:0]  wr_idx;

    logic hit;
    logic miss;

    assign hit  = (state_q == ST_IDLE) && bus.cpu_req_i && rd_valid && (rd_tag == req_tag);
    assign miss = (state_q == ST_IDLE) && bus.cpu_req_i && !hit;

    assign line_we = (state_q == ST_REFILL) && bus.mem_ack_i;
    assign word_we = hit && bus.cpu_write_i;
    assign wr_idx  = line_we ? fill_idx_q : req_idx;

    dcache_sram #(
        .LINES  (LINES),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W),
        .TG_W   (TG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (req_idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_idx_i    (wr_idx),
        .line_we_i   (line_we),
        .line_tag_i  (fill_tag_q),
        .line_data_i (bus.mem_data_i),
        .word_we_i   (word_we),
        .word_sel_i  (req_wsel),
        .word_data_i (bus.cpu_data_i)
    );

    // Miss handling FSM; memory outputs are set on entry to each state and
    // therefore hold steady for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        fill_tag_q   <= req_tag;
                        fill_idx_q   <= req_idx;
                        mem_enable_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q     <= ST_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {rd_tag, req_idx, {OFFSET_W{1'b0}}};
                            mem_data_q  <= rd_data;
                        end else begin
                            state_q     <= ST_REFILL;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                            mem_data_q  <= '0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state_q     <= ST_REFILL;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {fill_tag_q, fill_idx_q, {OFFSET_W{1'b0}}};
                        mem_data_q  <= '0;
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ack_i) begin
                        state_q      <= ST_IDLE;
                        mem_enable_q <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_data_q   <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    mem_enable_q <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_data_q   <= '0;
                end
            endcase
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

    // Stall is forced low while reset is held even if a request is pending.
    assign bus.cpu_stall_o = rst_i && ((state_q != ST_IDLE) || miss);
    assign bus.cpu_data_o  = hit ? rd_data[{req_wsel, 5'b00000} +: WORD_W] : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a line-memory responder with programmable
// latency, a flat word-level reference memory, and a load-data scoreboard.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_controller_if #(.LINE_W(256)) bus ();

    dcache_controller #(.LINES(16), .LINE_W(256)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference memory ----------------
    logic [255:0] mem_model [logic [31:0]];
    logic [31:0]  ref_word  [logic [31:0]];

    function automatic logic [31:0] pat_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
    endfunction

    function automatic logic [255:0] backing_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (ref_word.exists(wa)) return ref_word[wa];
        return pat_word(wa);
    endfunction

    // ---------------- memory responder ----------------
    int           lat = 1;
    int           cnt = 0;
    logic         ack_r = 1'b0;
    logic [255:0] rdata_r = '0;
    logic         spur = 1'b0;
    int           n_wb = 0;
    int           n_rf = 0;
    int           wr_cycles = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_rf_addr = '0;

    assign bus.mem_ack_i  = ack_r | spur;
    assign bus.mem_data_i = spur ? {256{1'b1}} : rdata_r;

    always @(posedge clk) begin
        #1;
        if (!rst_n || !bus.mem_enable_o || ack_r) cnt = 0;
        ack_r = 1'b0;
        if (rst_n && bus.mem_enable_o) begin
            if (bus.mem_write_o) wr_cycles++;
            cnt++;
            if (cnt >= lat) begin
                ack_r = 1'b1;
                if (bus.mem_write_o) begin
                    n_wb++;
                    last_wb_addr = bus.mem_addr_o;
                    mem_model[bus.mem_addr_o] = bus.mem_data_o;
                end else begin
                    n_rf++;
                    last_rf_addr = bus.mem_addr_o;
                    rdata_r = backing_line(bus.mem_addr_o);
                end
            end
        end
    end

    // ---------------- CPU driver and scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_stall;
        int          exp_wb_cycles;
        logic [31:0] exp_wb_addr;
        logic        exp_rf;
        logic [31:0] exp_rf_addr;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int l, input int st, input int wbc, input logic [31:0] wba,
                                input logic rf, input logic [31:0] rfa);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = l; v.exp_stall = st;
        v.exp_wb_cycles = wbc; v.exp_wb_addr = wba; v.exp_rf = rf; v.exp_rf_addr = rfa;
        return v;
    endfunction

    logic [31:0] exp_q [$];

    // Called at posedge+1; returns at posedge+1 with the request removed.
    task automatic run_vec(input vec_t v, input string name);
        int   stalls = 0;
        int   wb0 = n_wb;
        int   rf0 = n_rf;
        int   wc0 = wr_cycles;
        bit   done = 0;
        logic [31:0] exp;
        lat = v.lat;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_write_i = v.wr;
        bus.cpu_addr_i  = v.addr;
        bus.cpu_data_i  = v.wdata;
        if (!v.wr) exp_q.push_back(ref_read(v.addr));
        else ref_word[{v.addr[31:2], 2'b00}] = v.wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.cpu_stall_o) stalls++;
            else begin
                done = 1;
                if (!v.wr) begin
                    exp = exp_q.pop_front();
                    check({name, " data"}, bus.cpu_data_o, exp);
                end
            end
            @(posedge clk); #1;
        end
        bus.cpu_req_i   = 1'b0;
        bus.cpu_write_i = 1'b0;
        check({name, " completed"}, done, 1'b1);
        check({name, " stall"}, stalls, v.exp_stall);
        check({name, " wb write cycles"}, wr_cycles - wc0, v.exp_wb_cycles);
        check({name, " wb count"}, n_wb - wb0, (v.exp_wb_cycles > 0) ? 1 : 0);
        if (v.exp_wb_cycles > 0) check({name, " wb addr"}, last_wb_addr, v.exp_wb_addr);
        check({name, " refill count"}, n_rf - rf0, v.exp_rf ? 1 : 0);
        if (v.exp_rf) check({name, " refill addr"}, last_rf_addr, v.exp_rf_addr);
        $display("[TB] %s %s addr=%08h stall=%0d", name, v.wr ? "store" : "load", v.addr, stalls);
    endtask

    vec_t vecs [16];

    initial begin
        logic [255:0] l;
        int waited;

        bus.cpu_req_i   = 1'b1;
        bus.cpu_write_i = 1'b0;
        bus.cpu_addr_i  = 32'h40;
        bus.cpu_data_i  = '0;

        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat_word(32'h40 + 32'(w * 4));
        l[95:64] = 32'hDEAD_BEEF;
        mem_model[32'h40] = l;
        ref_word[32'h48]  = 32'hDEAD_BEEF;

        //            wr    addr     wdata          lat st  wbc wb_addr  rf    rf_addr
        vecs[0]  = mk(1'b0, 32'h040, 32'h0,          10, 11, 0, 32'h0,   1'b1, 32'h040);
        vecs[1]  = mk(1'b0, 32'h048, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 32'h044, 32'h1234_5678,   1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 32'h044, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 32'h244, 32'h0,           3,  7, 3, 32'h040, 1'b1, 32'h240);
        vecs[5]  = mk(1'b0, 32'h044, 32'h0,           2,  3, 0, 32'h0,   1'b1, 32'h040);
        vecs[6]  = mk(1'b1, 32'h600, 32'hCAFE_F00D,   4,  5, 0, 32'h0,   1'b1, 32'h600);
        vecs[7]  = mk(1'b0, 32'h600, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 32'h604, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 32'h048, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[10] = mk(1'b1, 32'h1E0, 32'h0BAD_C0DE,   1,  2, 0, 32'h0,   1'b1, 32'h1E0);
        vecs[11] = mk(1'b0, 32'h1FC, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[12] = mk(1'b0, 32'h1E0, 32'h0,           1,  0, 0, 32'h0,   1'b0, 32'h0);
        vecs[13] = mk(1'b0, 32'h3E0, 32'h0,           1,  3, 1, 32'h1E0, 1'b1, 32'h3E0);
        vecs[14] = mk(1'b0, 32'h000, 32'h0,           2,  5, 2, 32'h600, 1'b1, 32'h000);
        vecs[15] = mk(1'b0, 32'h1E0, 32'h0,           1,  2, 0, 32'h0,   1'b1, 32'h1E0);

        // Reset state, with a request pending to show the stall is suppressed.
        #12;
        check("reset stall", bus.cpu_stall_o, 1'b0);
        check("reset mem_enable", bus.mem_enable_o, 1'b0);
        check("reset mem_write", bus.mem_write_o, 1'b0);
        check("reset mem_addr", bus.mem_addr_o, 32'h0);
        check("reset mem_data", bus.mem_data_o, 256'h0);
        check("reset cpu_data", bus.cpu_data_o, 32'h0);
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        check("wb line 0x40 word1", mem_model[32'h40][63:32], 32'h1234_5678);
        check("wb line 0x40 word2", mem_model[32'h40][95:64], 32'hDEAD_BEEF);

        // Request dropped mid-refill: the line is still installed.
        lat = 5;
        bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h900;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop: stall in refill", bus.cpu_stall_o, 1'b1);
        bus.cpu_req_i = 1'b0;
        #1;
        check("drop: stall held without req", bus.cpu_stall_o, 1'b1);
        waited = 0;
        while (bus.mem_enable_o && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drop: transaction ended", bus.mem_enable_o, 1'b0);
        @(posedge clk); #1;
        run_vec(mk(1'b0, 32'h900, 32'h0, 1, 0, 0, 32'h0, 1'b0, 32'h0), "drop-hit");

        // Reset during refill abandons it; the line stays invalid.
        lat = 20;
        bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h800;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-reset enable", bus.mem_enable_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset enable", bus.mem_enable_o, 1'b0);
        check("mid reset stall", bus.cpu_stall_o, 1'b0);
        check("mid reset cpu_data", bus.cpu_data_o, 32'h0);
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(mk(1'b0, 32'h800, 32'h0, 2, 3, 0, 32'h0, 1'b1, 32'h800), "post-reset");

        // Spurious ack in idle with all-ones data on the bus.
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        check("spurious ack stall", bus.cpu_stall_o, 1'b0);
        check("spurious ack enable", bus.mem_enable_o, 1'b0);
        run_vec(mk(1'b0, 32'h800, 32'h0, 1, 0, 0, 32'h0, 1'b0, 32'h0), "spur-hit0");
        run_vec(mk(1'b0, 32'h804, 32'h0, 1, 0, 0, 32'h0, 1'b0, 32'h0), "spur-hit1");

        check("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
